rf_wb_arbiter: RTL

Write-port arbiter and scoreboard for the general-purpose register file. It shares the register file's single write port between two requesters: port 0 is pipeline writeback and port 1 is the long-latency unit (load/multiply/divide). It also tracks destination registers with outstanding long-latency results and flags read hazards to the issue stage. Outputs drive the register file's `a3`/`di3`/`we3` inputs directly.

---
 rtl/rf_wb_arbiter_if.sv | 62 ++++++
 rtl/rf_wb_arbiter.sv | 134 +++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter_if.sv
// Purpose: bundles the write-port arbiter's request, scoreboard and register-file signals.
// Latency: none; this is a signal bundle only.
// Backpressure: the arbiter drives the readies, and the requesters must hold each request until it is granted.
//
// Port summary:
//   p0_* : pipeline writeback request (valid/addr/data in, ready out)
//   p1_* : long-latency unit result (valid/addr/data in, ready out)
//   mark_* : issue-time busy marking of a long-latency destination
//   chk_a1/chk_a2 -> hazard : issue-stage source check
//   busy : scoreboard vector
//   rf_a3/rf_di3/rf_we3 : registered register-file write port
// Modports: master = requesters/issue side, slave = arbiter.
interface rf_wb_arbiter_if #(
    parameter int REG_CNT = 32,
    parameter int XLEN    = 32
);
    localparam int AW = $clog2(REG_CNT);

    logic               p0_valid;
    logic [AW-1:0]      p0_addr;
    logic [XLEN-1:0]    p0_data;
    logic               p0_ready;

    logic               p1_valid;
    logic [AW-1:0]      p1_addr;
    logic [XLEN-1:0]    p1_data;
    logic               p1_ready;

    logic               mark_valid;
    logic [AW-1:0]      mark_addr;

    logic [AW-1:0]      chk_a1;
    logic [AW-1:0]      chk_a2;
    logic               hazard;
    logic [REG_CNT-1:0] busy;

    logic [AW-1:0]      rf_a3;
    logic [XLEN-1:0]    rf_di3;
    logic               rf_we3;

    modport master (
        output p0_valid, p0_addr, p0_data,
        input  p0_ready,
        output p1_valid, p1_addr, p1_data,
        input  p1_ready,
        output mark_valid, mark_addr,
        output chk_a1, chk_a2,
        input  hazard, busy,
        input  rf_a3, rf_di3, rf_we3
    );

    modport slave (
        input  p0_valid, p0_addr, p0_data,
        output p0_ready,
        input  p1_valid, p1_addr, p1_data,
        output p1_ready,
        input  mark_valid, mark_addr,
        input  chk_a1, chk_a2,
        output hazard, busy,
        output rf_a3, rf_di3, rf_we3
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Purpose: shares the GPR write port between writeback (p0) and the long-latency unit (p1), and keeps the busy scoreboard.
// Latency: a grant in cycle N gives rf_we3 in N+1; a mark in N is visible on busy/hazard in N+1; p1 busy clears from N+2.
// Backpressure: readies are combinational; p0 has fixed priority, and p1 is force-granted after STARVE_MAX denials when enabled.
//
// Ports: clk, rst (async, active-high), bus (rf_wb_arbiter_if.slave).
// Optional feature: define RF_WB_ARB_STARVE_EN to build the port-1 starvation counter and forced grant.
// Without it, arbitration is strict fixed priority, and p1 can starve while p0 stays valid.
module rf_wb_arbiter #(
    parameter int REG_CNT    = 32,
    parameter int XLEN       = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst,
    rf_wb_arbiter_if.slave  bus
);
    localparam int AW = $clog2(REG_CNT);

    // The counter is 4 bits wide, so the threshold must fit in it.
    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
        $error("rf_wb_arbiter: STARVE_MAX must be in 1..15");
    end

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic force_p1;
    logic p0_grant;
    logic p1_grant;

`ifdef RF_WB_ARB_STARVE_EN
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0] starve_cnt;

    assign force_p1 = bus.p1_valid && (starve_cnt == STARVE_LIM);

    // The counter counts consecutive denials. It clears when p1 is granted or withdrawn,
    // and it saturates at the threshold so that the force stays asserted until the grant happens.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= 4'd0;
        end else if (!bus.p1_valid || p1_grant) begin
            starve_cnt <= 4'd0;
        end else if (starve_cnt != STARVE_LIM) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end
`else
    assign force_p1 = 1'b0;
`endif

    // Both readies are held low during reset, so that no handshake appears to complete.
    assign p0_grant = !rst && bus.p0_valid && !force_p1;
    assign p1_grant = !rst && bus.p1_valid && (!bus.p0_valid || force_p1);

    assign bus.p0_ready = p0_grant;
    assign bus.p1_ready = p1_grant;

    // ------------------------------------------------------------------
    // Registered write port
    // ------------------------------------------------------------------
    logic [AW-1:0]   wr_addr;
    logic [XLEN-1:0] wr_data;

    logic [AW-1:0]   rf_a3_q;
    logic [XLEN-1:0] rf_di3_q;
    logic            rf_we3_q;
    logic            src_p1_q;   // the write in flight came from p1, so it may retire a busy bit

    always_comb begin
        wr_addr = bus.p0_addr;
        wr_data = bus.p0_data;
        if (p1_grant) begin
            wr_addr = bus.p1_addr;
            wr_data = bus.p1_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_a3_q  <= '0;
            rf_di3_q <= '0;
            rf_we3_q <= 1'b0;
            src_p1_q <= 1'b0;
        end else if (p0_grant || p1_grant) begin
            // An address-0 write completes the handshake, but it never reaches the register file.
            rf_a3_q  <= wr_addr;
            rf_di3_q <= wr_data;
            rf_we3_q <= (wr_addr != '0);
            src_p1_q <= p1_grant;
        end else begin
            rf_we3_q <= 1'b0;
            src_p1_q <= 1'b0;
        end
    end

    assign bus.rf_a3  = rf_a3_q;
    assign bus.rf_di3 = rf_di3_q;
    assign bus.rf_we3 = rf_we3_q;

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    logic [REG_CNT-1:0] busy_q;
    logic [REG_CNT-1:0] busy_set;
    logic [REG_CNT-1:0] busy_clr;

    always_comb begin
        busy_set = '0;
        busy_clr = '0;
        if (bus.mark_valid && (bus.mark_addr != '0)) begin
            busy_set[bus.mark_addr] = 1'b1;
        end
        // A bit is retired only by the cycle in which the p1 result is actually written.
        if (rf_we3_q && src_p1_q) begin
            busy_clr[rf_a3_q] = 1'b1;
        end
    end

    // Set is applied after clear. A re-issue in the same cycle as the old result's write
    // keeps the register busy for the new result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= (busy_q & ~busy_clr) | busy_set;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.hazard = !rst && (busy_q[bus.chk_a1] || busy_q[bus.chk_a2]);

endmodule
